// File: rtl/prefetch_queue.sv
// Sequential byte prefetcher feeding the decoder: one MMU read in flight at a time,
// returned bytes buffered in a DEPTH-entry FIFO, redirect flushes and restarts fetch.
module prefetch_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirectAddr,
  output logic                     memRequest,
  output logic [ADDRESS_WIDTH-1:0] memAddr,
  input  logic                     memBusy,
  input  logic [BUS_WIDTH-1:0]     memData,
  output logic [BUS_WIDTH-1:0]     outByte,
  output logic [ADDRESS_WIDTH-1:0] outAddr,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [1:0]               dbgState,
  output logic [$clog2(DEPTH):0]   dbgCount
);
  // Decoder handshake: the head byte transfers on any posedge where outValid and
  // outReady are both high; outValid depends only on FIFO occupancy, never on outReady.
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} stateT;

  stateT                    state, stateNext;
  logic                     doIssue, doPush, doPop;
  logic [ADDRESS_WIDTH-1:0] fetchPtr;
  logic [PTR_W-1:0]         head, tail;
  logic [PTR_W:0]           count;
  logic [BUS_WIDTH-1:0]     fifo [DEPTH];

  assign outValid = (count != '0);
  assign outByte  = outValid ? fifo[head] : '0;
  assign doPop    = outValid & outReady & ~redirect;
  assign dbgState = state;
  assign dbgCount = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Only one read is ever outstanding, so reserving a slot at issue time means a
  // completing read always finds room in the FIFO.
  always_comb begin
    stateNext = state;
    doIssue   = 1'b0;
    doPush    = 1'b0;
    case (state)
      IDLE: begin
        if (count < (PTR_W+1)'(DEPTH)) begin
          doIssue   = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: stateNext = WAIT;
      WAIT: begin
        if (!memBusy) begin
          doPush    = 1'b1;
          stateNext = IDLE;
        end
      end
      DRAIN: begin
        if (!memBusy) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // A read accepted by the MMU but not yet returned must be swallowed in DRAIN.
    if (redirect) begin
      doIssue = 1'b0;
      doPush  = 1'b0;
      case (state)
        IDLE:    stateNext = IDLE;
        WAIT:    stateNext = memBusy ? DRAIN : IDLE;
        DRAIN:   stateNext = memBusy ? DRAIN : IDLE;
        default: stateNext = DRAIN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memRequest <= 1'b0;
      memAddr    <= '0;
      fetchPtr   <= RESET_VECTOR;
      outAddr    <= RESET_VECTOR;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      memRequest <= doIssue;
      if (doIssue) memAddr <= fetchPtr;
      if (redirect) begin
        fetchPtr <= redirectAddr;
        outAddr  <= redirectAddr;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (doPush) begin
          tail     <= tail + PTR_W'(1);
          fetchPtr <= fetchPtr + ADDRESS_WIDTH'(1);
        end
        if (doPop) begin
          head    <= head + PTR_W'(1);
          outAddr <= outAddr + ADDRESS_WIDTH'(1);
        end
        case ({doPush, doPop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) fifo[tail] <= memData;
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed + randomized bench for prefetch_queue: an MMU responder with variable latency
// and an address-stream scoreboard that predicts every issued address and popped byte.
module tb_prefetch_queue;
  localparam int AW = 32;
  localparam int BW = 8;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] RV_B = 32'hFFFF_FFFE;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic clk, reset, redirect, memRequest, memBusy, outValid, outReady;
  logic [AW-1:0] redirectAddr, memAddr, outAddr;
  logic [BW-1:0] memData, outByte;
  logic [1:0] dbgState;
  logic [CW-1:0] dbgCount;

  logic rstB, memRequestB, memBusyB, outValidB, outReadyB;
  logic [AW-1:0] memAddrB, outAddrB;
  logic [BW-1:0] memDataB, outByteB;
  logic [1:0] dbgStateB;
  logic [CW-1:0] dbgCountB;
  logic redirectB;
  logic [AW-1:0] redirectAddrB;

  prefetch_queue #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .DEPTH(DEPTH), .RESET_VECTOR(32'h0)) u_dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirectAddr(redirectAddr),
    .memRequest(memRequest), .memAddr(memAddr), .memBusy(memBusy), .memData(memData),
    .outByte(outByte), .outAddr(outAddr), .outValid(outValid), .outReady(outReady),
    .dbgState(dbgState), .dbgCount(dbgCount)
  );

  prefetch_queue #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .DEPTH(DEPTH), .RESET_VECTOR(RV_B)) u_dut_b (
    .clk(clk), .reset(rstB), .redirect(redirectB), .redirectAddr(redirectAddrB),
    .memRequest(memRequestB), .memAddr(memAddrB), .memBusy(memBusyB), .memData(memDataB),
    .outByte(outByteB), .outAddr(outAddrB), .outValid(outValidB), .outReady(outReadyB),
    .dbgState(dbgStateB), .dbgCount(dbgCountB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCnt = 0;
  int totalCnt = 0;
  int failCnt = 0;

  logic [7:0] dataSeed;
  logic [AW-1:0] latAddr, issueExp, issueExpB, popExpB, lastIssue, armAddr;
  logic [AW-1:0] exp_q[$];
  int busyCnt, latency, issueCnt, popCnt, issueCntB, popCntB;
  bit randLat, armRedirect, armFired;

  function automatic logic [7:0] byteAt(input logic [AW-1:0] a);
    return (a[7:0] * 8'd13) ^ a[15:8] ^ a[31:24] ^ dataSeed;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected decoder stream after reset/redirect: consecutive addresses from the start point.
  task automatic loadStream(input logic [AW-1:0] a);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(a + 32'(i));
  endtask

  // One clock: MMU responder and monitors act at negedge, DUT updates at posedge.
  task automatic cycle();
    logic [AW-1:0] e;
    @(negedge clk);
    if (memRequest) begin
      latAddr = memAddr;
      busyCnt = (randLat ? int'($urandom_range(0, 5)) : latency) + 1;
    end else if (busyCnt > 0) begin
      busyCnt--;
    end
    memBusy = (busyCnt != 0);
    memData = byteAt(latAddr);
    memDataB = byteAt(memAddrB);
    if (armRedirect && dbgState == S_WAIT && dbgCount == CW'(3) && !memBusy) begin
      redirect = 1'b1;
      redirectAddr = armAddr;
      outReady = 1'b1;
      armRedirect = 1'b0;
      armFired = 1'b1;
    end
    if (memRequest) begin
      chk("issue_addr", memAddr, issueExp);
      lastIssue = memAddr;
      issueExp = issueExp + 32'd1;
      issueCnt++;
    end
    if (outValid && outReady && !redirect) begin
      if (exp_q.size() == 0) chk("pop_extra", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("pop_addr", outAddr, e);
        chk("pop_byte", 32'(outByte), 32'(byteAt(e)));
        popCnt++;
      end
    end
    if (memRequestB) begin
      chk("b_issue_addr", memAddrB, issueExpB);
      issueExpB = issueExpB + 32'd1;
      issueCntB++;
    end
    if (outValidB && outReadyB) begin
      chk("b_pop_addr", outAddrB, popExpB);
      chk("b_pop_byte", 32'(outByteB), 32'(byteAt(popExpB)));
      popExpB = popExpB + 32'd1;
      popCntB++;
    end
    @(posedge clk);
    #1;
    if (redirect) begin
      loadStream(redirectAddr);
      issueExp = redirectAddr;
    end
    redirect = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_memRequest"}, 32'(memRequest), 32'd0);
    chk({tag, "_memAddr"}, memAddr, 32'd0);
    chk({tag, "_outValid"}, 32'(outValid), 32'd0);
    chk({tag, "_outByte"}, 32'(outByte), 32'd0);
    chk({tag, "_outAddr"}, outAddr, 32'd0);
    chk({tag, "_state"}, 32'(dbgState), 32'(S_IDLE));
    chk({tag, "_count"}, 32'(dbgCount), 32'd0);
  endtask

  initial begin
    int startPops;
    reset = 1'b1; rstB = 1'b1; redirect = 1'b0; redirectAddr = '0;
    redirectB = 1'b0; redirectAddrB = '0;
    outReady = 1'b0; outReadyB = 1'b0; memBusy = 1'b0; memBusyB = 1'b0;
    memData = '0; memDataB = '0; latAddr = '0; lastIssue = '0; armAddr = '0;
    busyCnt = 0; latency = 0; randLat = 1'b0; armRedirect = 1'b0; armFired = 1'b0;
    issueCnt = 0; popCnt = 0; issueCntB = 0; popCntB = 0;
    dataSeed = 8'($urandom);
    issueExp = '0; loadStream('0);
    issueExpB = RV_B; popExpB = RV_B;
    repeat (3) @(posedge clk);
    #1;

    // 1: reset values, then fill with zero-latency MMU and no consumer
    checkResetOutputs("t1_reset");
    reset = 1'b0;
    repeat (40) cycle();
    chk("t1_issue_count", 32'(issueCnt), 32'd8);
    chk("t1_memRequest_idle", 32'(memRequest), 32'd0);
    chk("t1_outValid", 32'(outValid), 32'd1);
    chk("t1_outAddr", outAddr, 32'd0);
    chk("t1_count_full", 32'(dbgCount), 32'd8);
    chk("t1_head_byte", 32'(outByte), 32'(byteAt(32'd0)));

    // 2: slow MMU, consumer always ready, 32 more reads through the full queue
    latency = 5;
    outReady = 1'b1;
    for (int i = 0; i < 800 && popCnt < 40; i++) cycle();
    chk("t2_pop_count", 32'(popCnt), 32'd40);
    chk("t2_outAddr", outAddr, 32'd40);

    // 3: redirect while the MMU is still busy on an outstanding read
    latency = 4;
    outReady = 1'b0;
    for (int i = 0; i < 50 && !(dbgState == S_WAIT && busyCnt > 1); i++) cycle();
    chk("t3_found_wait", 32'(dbgState == S_WAIT && busyCnt > 1), 32'd1);
    redirect = 1'b1;
    redirectAddr = 32'h100;
    cycle();
    chk("t3_state_drain", 32'(dbgState), 32'(S_DRAIN));
    chk("t3_outValid", 32'(outValid), 32'd0);
    chk("t3_outAddr", outAddr, 32'h100);
    outReady = 1'b1;
    startPops = popCnt;
    for (int i = 0; i < 200 && popCnt < startPops + 4; i++) cycle();
    chk("t3_pops", 32'(popCnt - startPops), 32'd4);

    // 4: redirect coinciding with a completion and a pop, three bytes queued
    redirect = 1'b1;
    redirectAddr = 32'h200;
    cycle();
    outReady = 1'b0;
    latency = 2;
    armAddr = $urandom;
    armRedirect = 1'b1;
    for (int i = 0; i < 200 && !armFired; i++) cycle();
    chk("t4_fired", 32'(armFired), 32'd1);
    chk("t4_outValid", 32'(outValid), 32'd0);
    chk("t4_count", 32'(dbgCount), 32'd0);
    chk("t4_state_idle", 32'(dbgState), 32'(S_IDLE));
    chk("t4_outAddr", outAddr, armAddr);
    startPops = popCnt;
    for (int i = 0; i < 200 && popCnt < startPops + 3; i++) cycle();
    chk("t4_pops", 32'(popCnt - startPops), 32'd3);

    // 5: second instance starting just below the top of the address space
    rstB = 1'b0;
    outReadyB = 1'b1;
    repeat (24) cycle();
    chk("t5_b_issues", 32'(issueCntB >= 3), 32'd1);
    chk("t5_b_pops", 32'(popCntB >= 3), 32'd1);

    // random consumer, random MMU latency, occasional redirects
    randLat = 1'b1;
    startPops = popCnt;
    for (int i = 0; i < 400; i++) begin
      outReady = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        redirect = 1'b1;
        redirectAddr = $urandom;
      end
      cycle();
    end
    chk("rand_progress", 32'(popCnt > startPops), 32'd1);
    randLat = 1'b0;

    // 6: asynchronous reset in the middle of an outstanding read
    latency = 6;
    outReady = 1'b0;
    for (int i = 0; i < 50 && !(dbgState == S_WAIT && busyCnt > 1); i++) cycle();
    chk("t6_found_wait", 32'(dbgState == S_WAIT && busyCnt > 1), 32'd1);
    reset = 1'b1;
    busyCnt = 0;
    memBusy = 1'b0;
    issueExp = '0;
    loadStream('0);
    #1;
    checkResetOutputs("t6_reset");
    cycle();
    cycle();
    reset = 1'b0;
    latency = 0;
    issueCnt = 0;
    for (int i = 0; i < 20 && issueCnt == 0; i++) cycle();
    chk("t6_issued", 32'(issueCnt), 32'd1);
    chk("t6_first_issue", lastIssue, 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
